// File: rtl/hc_buffer_bank_if.sv
// Command/data/status bundle for hc_buffer_bank: per-buffer slices packed side by side.
// The master modport is the request engine; the slave modport is the buffer bank.
interface hc_buffer_bank_if #(
  parameter int NUM_BUF = 4,
  parameter int DEPTH   = 64,
  parameter int DATA_W  = 512
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [2*NUM_BUF-1:0]      cmd;
  logic [DATA_W*NUM_BUF-1:0] wr_data;
  logic [NUM_BUF-1:0]        flush;
  logic [DATA_W*NUM_BUF-1:0] rd_data;
  logic [NUM_BUF-1:0]        rd_valid;
  logic [CNT_W*NUM_BUF-1:0]  count;
  logic [NUM_BUF-1:0]        empty;
  logic [NUM_BUF-1:0]        full;
  logic [NUM_BUF-1:0]        almost_full;
  logic [NUM_BUF-1:0]        err_ovf;
  logic [NUM_BUF-1:0]        err_udf;
  logic [CNT_W*NUM_BUF-1:0]  peak;

  modport master (
    output cmd, wr_data, flush,
    input  rd_data, rd_valid, count, empty, full, almost_full, err_ovf, err_udf, peak
  );

  modport slave (
    input  cmd, wr_data, flush,
    output rd_data, rd_valid, count, empty, full, almost_full, err_ovf, err_udf, peak
  );
endinterface

// File: rtl/hc_buffer_bank.sv
// Bank of NUM_BUF independent circular FIFOs with enqueue/dequeue/enq+deq commands, flush and sticky errors.
// Optional high-water mark per buffer when HC_BUFFER_BANK_STATS_EN is defined; otherwise peak reads 0.
module hc_buffer_bank #(
  parameter int NUM_BUF   = 4,
  parameter int DEPTH     = 64,
  parameter int DATA_W    = 512,
  parameter int AF_THRESH = 60
) (
  input logic               clk,
  input logic               reset,
  hc_buffer_bank_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, empty_q, full_q, af_q, ovf_q, udf_q;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] wdata;
    logic              flush, enq_req, deq_req, do_enq, do_deq;

    assign cmd   = bus.cmd[2*i +: 2];
    assign wdata = bus.wr_data[DATA_W*i +: DATA_W];
    assign flush = bus.flush[i];

    // cmd bit 0 requests an enqueue, bit 1 a dequeue; ENQ_DEQ sets both.
    // A dequeue frees a slot the same cycle, so a full buffer still accepts ENQ_DEQ.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
      enq_req = cmd[0] && !flush;
      deq_req = cmd[1] && !flush;
      do_deq  = deq_req && (count_q != '0);
      do_enq  = enq_req && ((count_q != CNT_W'(DEPTH)) || do_deq);
      count_d = count_q;
      if (flush)
        count_d = '0;
      else if (do_enq && !do_deq)
        count_d = count_q + CNT_W'(1);
      else if (do_deq && !do_enq)
        count_d = count_q - CNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
        empty_q    <= 1'b1;
        full_q     <= 1'b0;
        af_q       <= 1'b0;
        ovf_q      <= 1'b0;
        udf_q      <= 1'b0;
      end else begin
        count_q    <= count_d;
        empty_q    <= (count_d == '0);
        full_q     <= (count_d == CNT_W'(DEPTH));
        af_q       <= (count_d >= CNT_W'(AF_THRESH));
        rd_valid_q <= do_deq;
        if (do_deq)
          rd_data_q <= mem_q[rptr_q];
        if (flush) begin
          wptr_q <= '0;
          rptr_q <= '0;
          ovf_q  <= 1'b0;
          udf_q  <= 1'b0;
        end else begin
          if (do_enq)
            wptr_q <= wptr_q + PTR_W'(1);
          if (do_deq)
            rptr_q <= rptr_q + PTR_W'(1);
          if (enq_req && !do_enq)
            ovf_q <= 1'b1;
          if (deq_req && (count_q == '0))
            udf_q <= 1'b1;
        end
      end
    end

    // NOTE: storage has no reset; stale entries are unreachable behind the pointers.
    always_ff @(posedge clk) begin
      if (do_enq)
        mem_q[wptr_q] <= wdata;
    end

`ifdef HC_BUFFER_BANK_STATS_EN
    logic [CNT_W-1:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        peak_q <= '0;
      else if (flush)
        peak_q <= '0;
      else if (count_d > peak_q)
        peak_q <= count_d;
    end

    assign bus.peak[CNT_W*i +: CNT_W] = peak_q;
`else
    assign bus.peak[CNT_W*i +: CNT_W] = '0;
`endif

    assign bus.rd_data[DATA_W*i +: DATA_W] = rd_data_q;
    assign bus.rd_valid[i]                 = rd_valid_q;
    assign bus.count[CNT_W*i +: CNT_W]     = count_q;
    assign bus.empty[i]                    = empty_q;
    assign bus.full[i]                     = full_q;
    assign bus.almost_full[i]              = af_q;
    assign bus.err_ovf[i]                  = ovf_q;
    assign bus.err_udf[i]                  = udf_q;
  end
endmodule

// File: tb/tb_hc_buffer_bank.sv
// Directed bench for hc_buffer_bank (3 buffers, depth 4, 8-bit data): stimulus pushes expected
// dequeue data into per-buffer queues, a negedge monitor pops and compares on every rd_valid.
module tb_hc_buffer_bank;
  localparam int NB = 3;
  localparam int DP = 4;
  localparam int DW = 8;
  localparam int AF = 3;
  localparam int CW = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENQ    = 2'd1;
  localparam logic [1:0] DEQ    = 2'd2;
  localparam logic [1:0] ENQDEQ = 2'd3;

`ifdef HC_BUFFER_BANK_STATS_EN
  localparam int PEAK_AFTER_T6 = 3;
`else
  localparam int PEAK_AFTER_T6 = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hc_buffer_bank_if #(.NUM_BUF(NB), .DEPTH(DP), .DATA_W(DW)) bus ();

  hc_buffer_bank #(.NUM_BUF(NB), .DEPTH(DP), .DATA_W(DW), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [NB][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int b);
    return bus.count[CW*b +: CW];
  endfunction

  function automatic logic [CW-1:0] pk(input int b);
    return bus.peak[CW*b +: CW];
  endfunction

  // One clock of stimulus; outputs are stable 1 time unit after the edge.
  task automatic step(input logic [2*NB-1:0] c, input logic [DW*NB-1:0] d, input logic [NB-1:0] f);
    bus.cmd     = c;
    bus.wr_data = d;
    bus.flush   = f;
    @(posedge clk);
    #1;
    bus.cmd     = '0;
    bus.wr_data = '0;
    bus.flush   = '0;
  endtask

  task automatic op(input int b, input logic [1:0] c, input logic [DW-1:0] d);
    logic [2*NB-1:0]  cv = '0;
    logic [DW*NB-1:0] dv = '0;
    cv[2*b +: 2]  = c;
    dv[DW*b +: DW] = d;
    step(cv, dv, '0);
  endtask

  // Scoreboard monitor: every presented read must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.rd_valid[b]) begin
          if (exp_q[b].size() == 0)
            check($sformatf("rd_valid_unexpected[%0d]", b), 32'(bus.rd_valid[b]), 32'd0);
          else
            check($sformatf("rd_data[%0d]", b), 32'(bus.rd_data[DW*b +: DW]), 32'(exp_q[b].pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.cmd     = '0;
    bus.wr_data = '0;
    bus.flush   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // 1: reset state
    check("rst_empty",    32'(bus.empty),       32'h7);
    check("rst_full",     32'(bus.full),        32'h0);
    check("rst_af",       32'(bus.almost_full), 32'h0);
    check("rst_count",    32'(bus.count),       32'h0);
    check("rst_ovf",      32'(bus.err_ovf),     32'h0);
    check("rst_udf",      32'(bus.err_udf),     32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid),    32'h0);
    check("rst_rd_data",  32'(bus.rd_data),     32'h0);
    check("rst_peak",     32'(bus.peak),        32'h0);

    // 2: fill to full then drain in order
    op(0, ENQ, 8'hA);
    op(0, ENQ, 8'hB);
    check("t2_count2", 32'(cnt(0)), 32'd2);
    check("t2_af_off", 32'(bus.almost_full[0]), 32'd0);
    op(0, ENQ, 8'hC);
    check("t2_af_on", 32'(bus.almost_full[0]), 32'd1);
    op(0, ENQ, 8'hD);
    check("t2_count4", 32'(cnt(0)), 32'd4);
    check("t2_full",   32'(bus.full[0]),  32'd1);
    check("t2_empty0", 32'(bus.empty[0]), 32'd0);
    exp_q[0].push_back(8'hA); op(0, DEQ, '0);
    exp_q[0].push_back(8'hB); op(0, DEQ, '0);
    exp_q[0].push_back(8'hC); op(0, DEQ, '0);
    exp_q[0].push_back(8'hD); op(0, DEQ, '0);
    check("t2_count0", 32'(cnt(0)), 32'd0);
    check("t2_empty1", 32'(bus.empty[0]), 32'd1);
    check("t2_af_off2", 32'(bus.almost_full[0]), 32'd0);

    // 3: overflow while full, then ENQ_DEQ on a full buffer
    op(0, ENQ, 8'hA);
    op(0, ENQ, 8'hB);
    op(0, ENQ, 8'hC);
    op(0, ENQ, 8'hD);
    op(0, ENQ, 8'hF);
    check("t3_ovf",    32'(bus.err_ovf), 32'h1);
    check("t3_count4", 32'(cnt(0)), 32'd4);
    exp_q[0].push_back(8'hA); op(0, ENQDEQ, 8'hE);
    check("t3_count_ed", 32'(cnt(0)), 32'd4);
    check("t3_ovf_kept", 32'(bus.err_ovf), 32'h1);
    check("t3_full",     32'(bus.full[0]), 32'd1);
    exp_q[0].push_back(8'hB); op(0, DEQ, '0);
    exp_q[0].push_back(8'hC); op(0, DEQ, '0);
    exp_q[0].push_back(8'hD); op(0, DEQ, '0);
    exp_q[0].push_back(8'hE); op(0, DEQ, '0);
    check("t3_drained", 32'(cnt(0)), 32'd0);

    // 4: underflow, ENQ_DEQ on empty, flush overriding an enqueue
    op(0, DEQ, '0);
    check("t4_udf",      32'(bus.err_udf),  32'h1);
    check("t4_rdv_udf",  32'(bus.rd_valid), 32'h0);
    op(0, ENQDEQ, 8'h5);
    check("t4_count1",   32'(cnt(0)), 32'd1);
    check("t4_rdv_ed",   32'(bus.rd_valid), 32'h0);
    check("t4_udf_kept", 32'(bus.err_udf),  32'h1);
    step({IDLE, IDLE, ENQ}, {8'h0, 8'h0, 8'h7}, 3'b001);
    check("t4_fl_count", 32'(cnt(0)), 32'd0);
    check("t4_fl_ovf",   32'(bus.err_ovf), 32'h0);
    check("t4_fl_udf",   32'(bus.err_udf), 32'h0);
    check("t4_fl_empty", 32'(bus.empty[0]), 32'd1);

    // 5: buffer independence and pointer wrap
    step({DEQ, ENQ, ENQ}, {8'h0, 8'h22, 8'h11}, '0);
    check("t5_udf",    32'(bus.err_udf), 32'h4);
    check("t5_ovf",    32'(bus.err_ovf), 32'h0);
    check("t5_counts", 32'(bus.count),   32'({3'd0, 3'd1, 3'd1}));
    for (int k = 0; k < 10; k++) begin
      exp_q[1].push_back((k == 0) ? 8'h22 : 8'(8'h30 + k - 1));
      op(1, ENQDEQ, 8'(8'h30 + k));
    end
    check("t5_wrap_count", 32'(cnt(1)), 32'd1);
    exp_q[1].push_back(8'h39); op(1, DEQ, '0);
    exp_q[0].push_back(8'h11); op(0, DEQ, '0);
    check("t5_counts0", 32'(bus.count), 32'h0);

    // 6: high-water mark
    step('0, '0, 3'b100);
    op(2, ENQ, 8'h1);
    op(2, ENQ, 8'h2);
    op(2, ENQ, 8'h3);
    exp_q[2].push_back(8'h1); op(2, DEQ, '0);
    exp_q[2].push_back(8'h2); op(2, DEQ, '0);
    op(2, ENQ, 8'h4);
    check("t6_count", 32'(cnt(2)), 32'd2);
    check("t6_peak",  32'(pk(2)),  32'(PEAK_AFTER_T6));
    step('0, '0, 3'b100);
    check("t6_fl_peak",  32'(pk(2)),  32'd0);
    check("t6_fl_count", 32'(cnt(2)), 32'd0);

    // 7: reset during an in-flight read
    op(0, ENQ, 8'h9);
    bus.cmd = {IDLE, IDLE, DEQ};
    @(posedge clk);
    #1;
    check("t7_rdv_pre", 32'(bus.rd_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("t7_rdv_drop", 32'(bus.rd_valid), 32'h0);
    check("t7_count",    32'(bus.count),    32'h0);
    check("t7_empty",    32'(bus.empty),    32'h7);
    bus.cmd = '0;
    @(negedge clk);
    reset = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    for (int b = 0; b < NB; b++)
      check($sformatf("drained_q[%0d]", b), 32'(exp_q[b].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
